addsub_flag_buffer: RTL and testbench

Registered output stage placed directly downstream of the 4-bit ripple-carry adder/borrow-subtractor. Each cycle it can capture the subtractor's operands, mode, result and carry/borrow. From these it derives the condition flags C, Z, N and V. It holds up to two results in a valid/ready buffer for the consuming stage and keeps a saturating count of signed-overflow events.

---
 rtl/addsub_flag_buffer_if.sv | 34 +++
 rtl/addsub_flag_buffer.sv | 124 ++++++++++++
 tb/tb_addsub_flag_buffer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/addsub_flag_buffer_if.sv
// Handshake/data bundle between the add/sub unit, the flag buffer and its consumer.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready carry flow control in each direction.
interface addsub_flag_buffer_if;
  // upstream side: one add/sub result offered per cycle
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       mode;
  logic [3:0] result;
  logic       carry_borrow;
  // downstream side: head entry with derived flags
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic       out_mode;
  logic       out_c;
  logic       out_z;
  logic       out_n;
  logic       out_v;

  // producer of add/sub results and consumer of the buffer
  modport master (
    output in_valid, a, b, mode, result, carry_borrow, out_ready,
    input  in_ready, out_valid, out_result, out_mode, out_c, out_z, out_n, out_v
  );

  // the flag buffer itself
  modport slave (
    input  in_valid, a, b, mode, result, carry_borrow, out_ready,
    output in_ready, out_valid, out_result, out_mode, out_c, out_z, out_n, out_v
  );
endinterface

// File: rtl/addsub_flag_buffer.sv
// Registers add/sub results with derived C/Z/N/V flags in a 2-entry buffer; counts overflows.
// Latency: entry visible on out_* the edge it is pushed; poppable on the following edge.
// Backpressure: in_ready drops only when both entries are held, independent of out_ready.
module addsub_flag_buffer #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_p,
  addsub_flag_buffer_if.slave bus,
  input  logic               clear_count,
  output logic [CNT_W-1:0]   ovf_count
);

  typedef struct packed {
    logic [3:0] result;
    logic       mode;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, state_nxt;
  entry_t head, tail, new_entry;
  logic   push, pop;
  logic   load_head_in, load_head_tail, load_tail_in;

  // in_ready depends on state alone so a full buffer never accepts, even while popping
  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  assign bus.out_result = head.result;
  assign bus.out_mode   = head.mode;
  assign bus.out_c      = head.c;
  assign bus.out_z      = head.z;
  assign bus.out_n      = head.n;
  assign bus.out_v      = head.v;

  // derive flags from the incoming operands; C is reported as borrow when subtracting
  always_comb begin
    new_entry        = '0;
    new_entry.result = bus.result;
    new_entry.mode   = bus.mode;
    new_entry.c      = bus.mode ? ~bus.carry_borrow : bus.carry_borrow;
    new_entry.z      = (bus.result == 4'b0000);
    new_entry.n      = bus.result[3];
    if (bus.mode)
      new_entry.v = (bus.a[3] != bus.b[3]) && (bus.result[3] != bus.a[3]);
    else
      new_entry.v = (bus.a[3] == bus.b[3]) && (bus.result[3] != bus.a[3]);
  end

  // buffer occupancy register
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) state <= EMPTY;
    else         state <= state_nxt;
  end

  // next occupancy and which register each edge writes
  always_comb begin
    state_nxt      = state;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail_in   = 1'b0;
    unique case (state)
      EMPTY: begin
        if (push) begin
          state_nxt    = ONE;
          load_head_in = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_head_in = 1'b1;
        end else if (push) begin
          state_nxt    = FULL;
          load_tail_in = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_nxt      = ONE;
          load_head_tail = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // head/tail storage; head keeps its last value once the buffer drains
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (load_head_in)        head <= new_entry;
      else if (load_head_tail) head <= tail;
      if (load_tail_in)        tail <= new_entry;
    end
  end

  // saturating overflow counter; clear wins over a coincident overflow push
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)
      ovf_count <= '0;
    else if (clear_count)
      ovf_count <= '0;
    else if (push && new_entry.v && (ovf_count != CNT_MAX))
      ovf_count <= ovf_count + 1'b1;
  end

endmodule

// File: tb/tb_addsub_flag_buffer.sv
// Directed bench for addsub_flag_buffer: vector table plus hand-written multi-cycle sequences.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled at the same point.
// Backpressure: exercised by holding out_ready low with a third entry waiting upstream.
module tb_addsub_flag_buffer;

  logic       clk;
  logic       reset_p;
  logic       clear_count;
  logic [7:0] ovf_count;

  addsub_flag_buffer_if bus ();

  addsub_flag_buffer #(.CNT_W(8)) dut (
    .clk         (clk),
    .reset_p     (reset_p),
    .bus         (bus.slave),
    .clear_count (clear_count),
    .ovf_count   (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       mode;
    logic [3:0] result;
    logic       cb;
    logic       exp_c;
    logic       exp_z;
    logic       exp_n;
    logic       exp_v;
  } vec_t;

  vec_t vecs [8];
  int   total;
  int   bad;
  int   exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [3:0] a, input logic [3:0] b,
                       input logic mode, input logic [3:0] res, input logic cb);
    bus.in_valid     = vld;
    bus.a            = a;
    bus.b            = b;
    bus.mode         = mode;
    bus.result       = res;
    bus.carry_borrow = cb;
  endtask

  function automatic logic [31:0] out_word();
    return {23'd0, bus.out_result, bus.out_mode, bus.out_c, bus.out_z, bus.out_n, bus.out_v};
  endfunction

  initial begin
    total   = 0;
    bad     = 0;
    exp_cnt = 0;

    //              a      b     mode  result  cb    c     z     n     v
    vecs[0] = '{4'd5,  4'd3,  1'b0, 4'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{4'd3,  4'd5,  1'b1, 4'd14, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{4'd7,  4'd7,  1'b1, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{4'd9,  4'd8,  1'b0, 4'd1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{4'd8,  4'd1,  1'b1, 4'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{4'd0,  4'd0,  1'b1, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{4'd2,  4'd3,  1'b0, 4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    reset_p       = 1'b1;
    clear_count   = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    step();
    check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("reset out data",  out_word(),             32'd0);
    check("reset ovf_count", {24'd0, ovf_count},     32'd0);
    reset_p = 1'b0;
    step();
    check("post-reset in_ready", {31'd0, bus.in_ready}, 32'd1);

    // table: single push, then pop, with flag and counter checks
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].result, vecs[i].cb);
      step();
      if (vecs[i].exp_v) exp_cnt++;
      check($sformatf("vec%0d out_valid", i), {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("vec%0d entry", i), out_word(),
            {23'd0, vecs[i].result, vecs[i].mode, vecs[i].exp_c, vecs[i].exp_z,
             vecs[i].exp_n, vecs[i].exp_v});
      check($sformatf("vec%0d ovf_count", i), {24'd0, ovf_count}, exp_cnt);
      drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
      step();
      check($sformatf("vec%0d popped", i), {31'd0, bus.out_valid}, 32'd0);
    end
    check("empty head holds", {28'd0, bus.out_result}, 32'd5);

    // backpressure: three back-to-back offers with out_ready low
    bus.out_ready = 1'b0;
    drive(1'b1, 4'd1, 4'd0, 1'b0, 4'd1, 1'b0);
    step();
    check("bp one in_ready", {31'd0, bus.in_ready}, 32'd1);
    drive(1'b1, 4'd2, 4'd0, 1'b0, 4'd2, 1'b0);
    step();
    check("bp full in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("bp full head", {28'd0, bus.out_result}, 32'd1);
    drive(1'b1, 4'd3, 4'd0, 1'b0, 4'd3, 1'b0);
    step();
    check("bp held in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("bp held head", {28'd0, bus.out_result}, 32'd1);
    bus.out_ready = 1'b1;
    step();
    check("bp pop1 head", {28'd0, bus.out_result}, 32'd2);
    check("bp pop1 in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    check("bp pop2 head", {28'd0, bus.out_result}, 32'd3);
    check("bp pop2 out_valid", {31'd0, bus.out_valid}, 32'd1);
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    step();
    check("bp drained", {31'd0, bus.out_valid}, 32'd0);

    // simultaneous push and pop while holding one entry
    bus.out_ready = 1'b0;
    drive(1'b1, 4'd4, 4'd0, 1'b0, 4'd4, 1'b0);
    step();
    check("pp head4", {28'd0, bus.out_result}, 32'd4);
    bus.out_ready = 1'b1;
    drive(1'b1, 4'd9, 4'd0, 1'b0, 4'd9, 1'b0);
    step();
    check("pp head9", {28'd0, bus.out_result}, 32'd9);
    check("pp in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("pp out_valid", {31'd0, bus.out_valid}, 32'd1);
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    step();
    check("pp drained", {31'd0, bus.out_valid}, 32'd0);

    // counter saturation and clear priority
    clear_count = 1'b1;
    step();
    check("cnt cleared", {24'd0, ovf_count}, 32'd0);
    clear_count = 1'b0;
    drive(1'b1, 4'd5, 4'd3, 1'b0, 4'd8, 1'b0);
    for (int i = 0; i < 300; i++) step();
    check("cnt saturated", {24'd0, ovf_count}, 32'd255);
    clear_count = 1'b1;
    step();
    check("cnt clear over ovf", {24'd0, ovf_count}, 32'd0);
    clear_count = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    step();
    check("cnt idle", {24'd0, ovf_count}, 32'd0);

    // asynchronous reset while full
    bus.out_ready = 1'b0;
    drive(1'b1, 4'd5, 4'd3, 1'b0, 4'd8, 1'b0);
    step();
    step();
    check("rst pre in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst pre ovf", {24'd0, ovf_count}, 32'd2);
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    #2;
    reset_p = 1'b1;
    #1;
    check("arst out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("arst out data",  out_word(),             32'd0);
    check("arst ovf_count", {24'd0, ovf_count},     32'd0);
    step();
    reset_p = 1'b0;
    step();
    check("arst released in_ready", {31'd0, bus.in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
